alarm_controller: RTL and testbench



---
 rtl/alarm_controller.sv | 137 +++++++++++++
 tb/tb_alarm_controller.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/alarm_controller.sv
// Alarm controller: siren, blinking light, acknowledge and event counter.
// Optional auto-silence timeout enabled by defining ALARM_TIMEOUT_EN.
module alarm_controller #(
  parameter int BLINK_HALF = 4,
  parameter int HOLD_MIN   = 16,
  parameter int CNT_W      = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alarme,
  input  logic             ack,
  output logic             sirene,
  output logic             luz,
  output logic             ativo,
  output logic [CNT_W-1:0] contagem
);

  typedef enum logic [1:0] {
    IDLE,
    ALERTA,
    SILENCIO
  } state_t;

  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int HW = (HOLD_MIN > 1) ? $clog2(HOLD_MIN) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_MIN - 1);

  state_t          state;
  logic            alarme_q;
  logic [BW-1:0]   blink_cnt;
  logic [HW-1:0]   hold_cnt;
  logic            evt;
  logic            cnt_max;
  logic            ack_ok;
  logic            tmo_hit;
  logic            release_a;

  assign evt       = alarme & ~alarme_q;
  assign cnt_max   = &contagem;
  assign ack_ok    = ack && (hold_cnt == HOLD_LAST);
  assign release_a = ack_ok | tmo_hit;

`ifdef ALARM_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] tmo_cnt;

  assign tmo_hit = (tmo_cnt == TMO_LAST);

  // Consecutive ALERTA cycles since entry or the latest event
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (state != ALERTA || evt || release_a) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sirene    <= 1'b0;
      luz       <= 1'b0;
      ativo     <= 1'b0;
      contagem  <= '0;
      alarme_q  <= 1'b0;
      blink_cnt <= '0;
      hold_cnt  <= '0;
    end else begin
      alarme_q <= alarme;
      if (evt && !cnt_max) begin
        contagem <= contagem + 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (evt) begin
            state     <= ALERTA;
            sirene    <= 1'b1;
            luz       <= 1'b1;
            ativo     <= 1'b1;
            blink_cnt <= '0;
            hold_cnt  <= '0;
          end
        end
        ALERTA: begin
          if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            luz       <= ~luz;
          end else begin
            blink_cnt <= blink_cnt + 1'b1;
          end
          // A fresh event beats a same-edge acknowledge
          if (evt) begin
            hold_cnt <= '0;
          end else if (release_a) begin
            sirene <= 1'b0;
            if (alarme) begin
              state <= SILENCIO;
              luz   <= 1'b1;
              ativo <= 1'b1;
            end else begin
              state <= IDLE;
              luz   <= 1'b0;
              ativo <= 1'b0;
            end
          end else if (hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        SILENCIO: begin
          sirene <= 1'b0;
          luz    <= 1'b1;
          if (!alarme) begin
            state <= IDLE;
            luz   <= 1'b0;
            ativo <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          sirene <= 1'b0;
          luz    <= 1'b0;
          ativo  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller with hand-computed expectations.
// Inputs change 1ns after a rising edge; outputs are checked there too.
module tb_alarm_controller;

  logic       clk;
  logic       reset;
  logic       alarme;
  logic       ack;
  logic       sirene;
  logic       luz;
  logic       ativo;
  logic [7:0] contagem;

  int checks = 0;
  int errors = 0;

  alarm_controller #(
    .BLINK_HALF(4),
    .HOLD_MIN  (16),
    .CNT_W     (8),
    .TIMEOUT   (64)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .alarme  (alarme),
    .ack     (ack),
    .sirene  (sirene),
    .luz     (luz),
    .ativo   (ativo),
    .contagem(contagem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic s, input logic l,
                         input logic a, input logic [7:0] c);
    chk({tag, ".sirene"}, 32'(sirene), 32'(s));
    chk({tag, ".luz"}, 32'(luz), 32'(l));
    chk({tag, ".ativo"}, 32'(ativo), 32'(a));
    chk({tag, ".contagem"}, 32'(contagem), 32'(c));
  endtask

  initial begin
    int exp_c;
    reset  = 1'b1;
    alarme = 1'b0;
    ack    = 1'b0;
    tick();
    tick();
    chk_out("reset", 1'b0, 1'b0, 1'b0, 8'd0);
    reset = 1'b0;

    // 1/2: entry, blink pattern, early ack ignored, SILENCIO, back to IDLE
    for (int i = 0; i < 4; i++) tick();
    chk_out("idle", 1'b0, 1'b0, 1'b0, 8'd0);
    alarme = 1'b1;
    tick();
    chk_out("entry", 1'b1, 1'b1, 1'b1, 8'd1);
    ack = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      chk($sformatf("hold_sir%0d", k), 32'(sirene), 32'd1);
      chk($sformatf("blink%0d", k), 32'(luz),
          32'(((k / 4) % 2) == 0));
    end
    tick();
    chk_out("silencio", 1'b0, 1'b1, 1'b1, 8'd1);
    tick();
    tick();
    chk_out("sil_ack", 1'b0, 1'b1, 1'b1, 8'd1);
    alarme = 1'b0;
    ack    = 1'b0;
    tick();
    chk_out("sil_idle", 1'b0, 1'b0, 1'b0, 8'd1);

    // 3: re-event in ALERTA restarts hold, blink phase untouched
    alarme = 1'b1;
    tick();
    chk_out("entry2", 1'b1, 1'b1, 1'b1, 8'd2);
    tick();
    tick();
    tick();
    alarme = 1'b0;
    tick();
    chk_out("drop_stay", 1'b1, 1'b0, 1'b1, 8'd2);
    alarme = 1'b1;
    tick();
    chk_out("reevt", 1'b1, 1'b0, 1'b1, 8'd3);
    ack = 1'b1;
    for (int k = 6; k <= 20; k++) tick();
    chk_out("rehold", 1'b1, 1'b0, 1'b1, 8'd3);
    tick();
    chk_out("rehold_rel", 1'b0, 1'b1, 1'b1, 8'd3);
    alarme = 1'b0;
    ack    = 1'b0;
    tick();
    chk_out("idle3", 1'b0, 1'b0, 1'b0, 8'd3);

    // 3b: ack and event on the same edge, event wins
    alarme = 1'b1;
    tick();
    chk_out("entry3", 1'b1, 1'b1, 1'b1, 8'd4);
    for (int k = 1; k <= 14; k++) tick();
    alarme = 1'b0;
    tick();
    alarme = 1'b1;
    ack    = 1'b1;
    tick();
    chk_out("ack_evt", 1'b1, 1'b1, 1'b1, 8'd5);
    for (int k = 17; k <= 31; k++) tick();
    chk("ack_evt_hold", 32'(sirene), 32'd1);
    tick();
    chk_out("ack_evt_rel", 1'b0, 1'b1, 1'b1, 8'd5);
    alarme = 1'b0;
    ack    = 1'b0;
    tick();
    chk_out("idle4", 1'b0, 1'b0, 1'b0, 8'd5);

    // 4: counter saturation
    for (int i = 0; i < 300; i++) begin
      alarme = 1'b1;
      tick();
      alarme = 1'b0;
      tick();
      exp_c = (6 + i > 255) ? 255 : 6 + i;
      chk($sformatf("sat%0d", i), 32'(contagem), 32'(exp_c));
    end
    chk("sat_sir", 32'(sirene), 32'd1);

    // 5: reset mid-ALERTA with alarme held
    alarme = 1'b1;
    tick();
    chk("pre_rst", 32'(contagem), 32'd255);
    reset = 1'b1;
    tick();
    chk_out("mid_rst", 1'b0, 1'b0, 1'b0, 8'd0);
    reset = 1'b0;
    tick();
    chk_out("post_rst", 1'b1, 1'b1, 1'b1, 8'd1);

    // 6: no ack with alarme held
    for (int k = 1; k <= 200; k++) begin
      tick();
`ifdef ALARM_TIMEOUT_EN
      chk($sformatf("tmo_sir%0d", k), 32'(sirene), 32'(k < 64));
      if (k >= 64) chk($sformatf("tmo_luz%0d", k), 32'(luz), 32'd1);
`else
      chk($sformatf("tmo_sir%0d", k), 32'(sirene), 32'd1);
`endif
    end
    chk("tmo_ativo", 32'(ativo), 32'd1);

    // 7: accepted ack with alarme low goes straight to IDLE
    reset  = 1'b1;
    alarme = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    alarme = 1'b1;
    tick();
    chk_out("entry7", 1'b1, 1'b1, 1'b1, 8'd1);
    alarme = 1'b0;
    ack    = 1'b1;
    for (int k = 1; k <= 15; k++) tick();
    chk_out("hold7", 1'b1, 1'b0, 1'b1, 8'd1);
    tick();
    chk_out("ack_idle", 1'b0, 1'b0, 1'b0, 8'd1);
    ack = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
